fp_rec_sched: RTL and testbench

FP_REC_SCHED -- requirements
Module: fp_rec_sched

---
 rtl/fp_rec_sched.sv | 183 ++++++++++++++++++
 tb/tb_fp_rec_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_rec_sched.sv
// fp_rec_sched: round-robin scheduler that feeds signed fixed-point operands from
// NREQ requesters into an external fixed-latency reciprocal core. A tag pipeline
// follows each operand through the core. Results return in acceptance order
// through a small FIFO. A credit rule (in-flight + buffered < DEPTH) throttles
// issue so that the FIFO can never overflow.
module fp_rec_sched #(
   parameter int WL    = 16,
   parameter int NREQ  = 4,
   parameter int LAT   = 3,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     CE,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*WL-1:0]       req_din,
   output logic [NREQ-1:0]          req_ready,
   output logic signed [WL-1:0]     core_din,
   output logic                     core_ce,
   input  logic signed [WL-1:0]     core_dout,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic signed [WL-1:0]     rsp_data,
   output logic [$clog2(NREQ)-1:0]  rsp_id
);

   localparam int IDW = $clog2(NREQ);
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int EW  = IDW + WL;

   // FIFO pointers wrap modulo DEPTH, which need not be a power of two
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   // arbitration
   logic [IDW-1:0]        last_grant_q, last_grant_d;
   logic [IDW-1:0]        cand;
   logic [IDW-1:0]        win_id;
   logic                  win_found;
   logic signed [WL-1:0]  win_din;
   logic                  credit_ok;
   logic                  accept;

   // issue and tag pipeline
   logic signed [WL-1:0]  core_din_q, core_din_d;
   logic [LAT-1:0]        tag_vld_q, tag_vld_d;
   logic [IDW-1:0]        tag_id_q [LAT];
   logic [CW-1:0]         inflight_q, inflight_d;

   // result FIFO
   logic [EW-1:0]         mem_q [DEPTH];
   logic [EW-1:0]         head;
   logic [CW-1:0]         count_q, count_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  push;
   logic                  pop;

   // Round-robin search starting one past the last granted requester
   always_comb begin
      win_found = 1'b0;
      win_id    = last_grant_q;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(last_grant_q) + k) % NREQ);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   assign win_din   = $signed(req_din[win_id*WL +: WL]);
   assign credit_ok = ({1'b0, inflight_q} + {1'b0, count_q}) < (CW+1)'(DEPTH);

   // Grant only the winner, and only when a FIFO slot is reserved for its result
   always_comb begin
      req_ready = '0;
      if (!RST && CE && credit_ok && win_found) begin
         req_ready[win_id] = 1'b1;
      end
   end

   assign accept = |req_ready;
   assign push   = CE & tag_vld_q[LAT-1];
   assign pop    = rsp_valid & rsp_ready;

   // Next state of issue path: operand register, grant pointer and tag valids
   always_comb begin
      last_grant_d = last_grant_q;
      core_din_d   = core_din_q;
      tag_vld_d    = tag_vld_q;
      if (accept) begin
         last_grant_d = win_id;
         core_din_d   = win_din;
      end
      if (CE) begin
         tag_vld_d[0] = accept;
         for (int s = 1; s < LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
         end
      end
   end

   // Next state of occupancy counters and FIFO pointers
   always_comb begin
      inflight_d = inflight_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      case ({accept, push})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
   end

   // Control state; reset discards every in-flight tag and buffered result
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         last_grant_q <= IDW'(NREQ - 1);
         core_din_q   <= '0;
         tag_vld_q    <= '0;
         inflight_q   <= '0;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         core_din_q   <= core_din_d;
         tag_vld_q    <= tag_vld_d;
         inflight_q   <= inflight_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
      end
   end

   // Requester ids ride alongside the operand; qualified by tag_vld_q
   always_ff @(posedge CLK) begin
      if (CE) begin
         tag_id_q[0] <= win_id;
         for (int s = 1; s < LAT; s++) begin
            tag_id_q[s] <= tag_id_q[s-1];
         end
      end
   end

   // Capture {id, result} from the core when the matching tag leaves the pipe
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {tag_id_q[LAT-1], core_dout};
      end
   end

   assign head      = mem_q[rd_ptr_q];
   assign rsp_valid = (count_q != '0);
   assign rsp_data  = rsp_valid ? $signed(head[WL-1:0]) : '0;
   assign rsp_id    = rsp_valid ? head[EW-1:WL] : '0;
   assign core_din  = core_din_q;
   assign core_ce   = CE;

   // Credit accounting must make a push into a full FIFO impossible
   a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
      !(push && !pop && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_fp_rec_sched.sv
// Bench for fp_rec_sched: a behavioural reciprocal core, a negedge monitor that
// queues expected results on every accept and compares them on every pop, and
// directed scenarios for latency, rotation, backpressure, CE gaps and reset.
module tb_fp_rec_sched;

   localparam int WL    = 16;
   localparam int NREQ  = 4;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;

   logic               CLK = 1'b0;
   logic               RST = 1'b0;
   logic               CE  = 1'b1;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ*WL-1:0] req_din   = '0;
   logic [NREQ-1:0]    req_ready;
   logic [WL-1:0]      core_din;
   logic               core_ce;
   logic [WL-1:0]      core_dout;
   logic               rsp_valid;
   logic               rsp_ready = 1'b0;
   logic [WL-1:0]      rsp_data;
   logic [1:0]         rsp_id;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   logic [17:0] sb [$];
   logic [17:0] e;

   fp_rec_sched #(.WL(WL), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .CE        (CE),
      .req_valid (req_valid),
      .req_din   (req_din),
      .req_ready (req_ready),
      .core_din  (core_din),
      .core_ce   (core_ce),
      .core_dout (core_dout),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id)
   );

   always #5 CLK = ~CLK;

   // Q8.8 reciprocal: 1/x = 65536/x in raw units, saturated to 16 bits
   function automatic logic [15:0] recip(input logic [15:0] x);
      int xs;
      int q;
      xs = int'($signed(x));
      if (xs == 0) return 16'h7fff;
      q = 65536 / xs;
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return q[15:0];
   endfunction

   // Core model: the registered core_din counts as the first of LAT stages
   logic [15:0] cpipe [LAT-1] = '{default: '0};
   always @(posedge CLK) begin
      if (core_ce) begin
         cpipe[0] <= core_din;
         for (int s = 1; s < LAT - 1; s++) cpipe[s] <= cpipe[s-1];
      end
   end
   assign core_dout = recip(cpipe[LAT-2]);

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Scoreboard: pop/compare on response handshake, push on accept
   always @(negedge CLK) begin
      if (!RST) begin
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               check_eq("sb_unexpected_rsp", rsp_valid, 0);
            end else begin
               e = sb.pop_front();
               check_eq("rsp_data", rsp_data, e[15:0]);
               check_eq("rsp_id", rsp_id, e[17:16]);
            end
         end
         if (CE && req_ready != '0) begin
            check_eq("ready_onehot", $countones(req_ready), 1);
            for (int r = 0; r < NREQ; r++) begin
               if (req_ready[r]) sb.push_back({2'(r), recip(req_din[r*WL +: WL])});
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic rand_din();
      for (int r = 0; r < NREQ; r++) req_din[r*WL +: WL] = 16'($urandom());
   endtask

   task automatic do_reset();
      RST = 1'b1;
      sb.delete();
      tick();
      tick();
      RST = 1'b0;
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_ready = 1'b1;
      CE        = 1'b1;
      for (int i = 0; i < 60 && (sb.size() != 0 || rsp_valid); i++) tick();
      check_eq("drain_empty", sb.size(), 0);
   endtask

   // Counts samples with a grant over the given number of cycles
   task automatic run_count(input int cycles, output int nacc);
      nacc = 0;
      for (int c = 0; c < cycles; c++) begin
         rand_din();
         #1;
         if (req_ready != '0) nacc++;
         tick();
      end
   endtask

   int n;
   int e0;
   int stale;
   int gid[$];
   int gcyc[$];
   int lim;

   initial begin
      // reset state
      #1;
      RST = 1'b1;
      req_valid = '1;
      tick();
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_rsp_data", rsp_data, 0);
      check_eq("rst_rsp_id", rsp_id, 0);
      check_eq("rst_core_din", core_din, 0);
      tick();
      RST = 1'b0;
      req_valid = '0;

      // single request: requester 1, 2.0 -> 0.5
      req_valid = 4'b0010;
      req_din[1*WL +: WL] = 16'h0200;
      rsp_ready = 1'b1;
      #1;
      check_eq("single_ready", req_ready, 4'b0010);
      tick();
      e0 = cyc;
      req_valid = '0;
      #1;
      while (!rsp_valid && cyc - e0 < 20) begin tick(); #1; end
      check_eq("single_latency", cyc - e0, LAT);
      check_eq("single_data", rsp_data, 16'h0080);
      check_eq("single_id", rsp_id, 1);
      tick();
      drain();

      // all requesters busy: rotation order and first DEPTH grants back-to-back
      do_reset();
      rsp_ready = 1'b1;
      req_valid = '1;
      for (int c = 0; c < 24; c++) begin
         rand_din();
         #1;
         for (int r = 0; r < NREQ; r++) begin
            if (req_ready[r]) begin gid.push_back(r); gcyc.push_back(c); end
         end
         tick();
      end
      check_eq("rr_count_ge8", gid.size() >= 8, 1);
      lim = (gid.size() < 8) ? gid.size() : 8;
      for (int k = 0; k < lim; k++) check_eq("rr_order", gid[k], k % NREQ);
      for (int k = 1; k < lim && k < DEPTH; k++) check_eq("rr_no_gap", gcyc[k] - gcyc[0], k);
      drain();

      // backpressure: DEPTH accepts, then one accept per pop
      rsp_ready = 1'b0;
      req_valid = '1;
      run_count(12, n);
      check_eq("bp_accepts", n, DEPTH);
      #1;
      check_eq("bp_stall", req_ready, 0);
      tick();
      for (int p = 0; p < 2; p++) begin
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
         run_count(8, n);
         check_eq("bp_one_per_pop", n, 1);
      end

      // full FIFO: one pop, then push and pop on the same edge
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
      check_eq("pp_ready_after_pop", req_ready != '0, 1);
      tick();
      tick();
      tick();
      rsp_ready = 1'b1;
      #1;
      check_eq("pp_stall_credit", req_ready, 0);
      tick();
      rsp_ready = 1'b0;
      #1;
      check_eq("pp_ready_after_pushpop", req_ready != '0, 1);
      tick();
      run_count(6, n);
      check_eq("pp_stays_full", n, 0);
      drain();

      // CE held low for 5 cycles with one result in flight
      rsp_ready = 1'b1;
      req_valid = 4'b0100;
      req_din[2*WL +: WL] = 16'h0080;
      #1;
      check_eq("ce_ready", req_ready, 4'b0100);
      tick();
      e0 = cyc;
      req_valid = '0;
      tick();
      CE = 1'b0;
      req_valid = 4'b0001;
      #1;
      check_eq("ce_low_no_ready", req_ready, 0);
      for (int i = 0; i < 5; i++) tick();
      CE = 1'b1;
      req_valid = '0;
      #1;
      while (!rsp_valid && cyc - e0 < 30) begin tick(); #1; end
      check_eq("ce_latency", cyc - e0, LAT + 5);
      check_eq("ce_data", rsp_data, 16'h0200);
      check_eq("ce_id", rsp_id, 2);
      tick();
      drain();

      // reset with two results in flight and one buffered
      do_reset();
      rsp_ready = 1'b0;
      req_valid = 4'b1110;
      rand_din();
      #1;
      check_eq("mf_grant1", req_ready, 4'b0010);
      tick();
      #1;
      check_eq("mf_grant2", req_ready, 4'b0100);
      tick();
      #1;
      check_eq("mf_grant3", req_ready, 4'b1000);
      tick();
      req_valid = '0;
      tick();
      check_eq("mf_buffered", rsp_valid, 1);
      RST = 1'b1;
      sb.delete();
      #1;
      check_eq("mf_rsp_valid_async", rsp_valid, 0);
      tick();
      tick();
      RST = 1'b0;
      rsp_ready = 1'b1;
      stale = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (rsp_valid) stale++;
         tick();
      end
      check_eq("mf_no_stale", stale, 0);
      req_valid = '1;
      rand_din();
      #1;
      check_eq("mf_next_grant", req_ready, 4'b0001);
      tick();
      drain();

      // random traffic with random CE and consumer stalls
      for (int c = 0; c < 400; c++) begin
         req_valid = 4'($urandom());
         rand_din();
         rsp_ready = ($urandom_range(0, 3) != 0);
         CE        = ($urandom_range(0, 7) != 0);
         tick();
      end
      drain();
      #1;
      check_eq("end_rsp_valid", rsp_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
